// File: rtl/fifo_bank.sv
// Bank of independent synchronous FIFOs with one shared write port and one shared read port.
// The read word is registered; status flags decode the registered per-queue counts only.
module fifo_bank #(
  parameter int QUEUE_QUANTITY  = 4,
  parameter int DATA_BITS       = 8,
  parameter int DEPTH           = 8,
  parameter int ALMOST_FULL_LVL = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_enb,
  input  logic [$clog2(QUEUE_QUANTITY)-1:0] wr_sel,
  input  logic [DATA_BITS-1:0]              data_in,
  input  logic                              rd_enb,
  input  logic [$clog2(QUEUE_QUANTITY)-1:0] rd_sel,
  output logic [DATA_BITS-1:0]              data_out,
  output logic                              valid_out,
  output logic [QUEUE_QUANTITY-1:0]         buf_empty,
  output logic [QUEUE_QUANTITY-1:0]         buf_full,
  output logic [QUEUE_QUANTITY-1:0]         almost_full,
  output logic                              err_overflow,
  output logic                              err_underflow
);

  localparam int SW = $clog2(QUEUE_QUANTITY);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_BITS-1:0] mem_q [QUEUE_QUANTITY][DEPTH];

  logic [AW-1:0] wptr_q  [QUEUE_QUANTITY];
  logic [AW-1:0] wptr_d  [QUEUE_QUANTITY];
  logic [AW-1:0] rptr_q  [QUEUE_QUANTITY];
  logic [AW-1:0] rptr_d  [QUEUE_QUANTITY];
  logic [CW-1:0] count_q [QUEUE_QUANTITY];
  logic [CW-1:0] count_d [QUEUE_QUANTITY];

  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 valid_out_q, valid_out_d;
  logic                 err_ovf_q, err_ovf_d;
  logic                 err_udf_q, err_udf_d;
  logic                 wr_ok, rd_ok;

  always_comb begin
    buf_empty   = '0;
    buf_full    = '0;
    almost_full = '0;
    for (int q = 0; q < QUEUE_QUANTITY; q++) begin
      buf_empty[q]   = (count_q[q] == '0);
      buf_full[q]    = (count_q[q] == CW'(DEPTH));
      almost_full[q] = (count_q[q] >= CW'(ALMOST_FULL_LVL));
    end
  end

  // A full queue still takes a write when the same edge pops it, since a slot frees up.
  assign rd_ok = rd_enb && !buf_empty[rd_sel];
  assign wr_ok = wr_enb && (!buf_full[wr_sel] || (rd_ok && (rd_sel == wr_sel)));

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    err_ovf_d   = wr_enb && !wr_ok;
    err_udf_d   = rd_enb && !rd_ok;
    for (int q = 0; q < QUEUE_QUANTITY; q++) begin
      if (wr_ok && (wr_sel == SW'(q))) wptr_d[q] = wptr_q[q] + AW'(1);
      if (rd_ok && (rd_sel == SW'(q))) rptr_d[q] = rptr_q[q] + AW'(1);
      case ({wr_ok && (wr_sel == SW'(q)), rd_ok && (rd_sel == SW'(q))})
        2'b10:   count_d[q] = count_q[q] + CW'(1);
        2'b01:   count_d[q] = count_q[q] - CW'(1);
        default: count_d[q] = count_q[q];
      endcase
    end
    if (rd_ok) begin
      data_out_d  = mem_q[rd_sel][rptr_q[rd_sel]];
      valid_out_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '{default: '0};
      rptr_q      <= '{default: '0};
      count_q     <= '{default: '0};
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_udf_q   <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      err_ovf_q   <= err_ovf_d;
      err_udf_q   <= err_udf_d;
    end
  end

  // NOTE: storage is deliberately left unreset; the counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wr_sel][wptr_q[wr_sel]] <= data_in;
  end

  assign data_out      = data_out_q;
  assign valid_out     = valid_out_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_udf_q;

endmodule

// File: doc/fifo_bank.md
Name: fifo_bank

Overview:
- Bank of QUEUE_QUANTITY independent synchronous FIFOs sharing one write port and one read port.
- Sits directly upstream of the round-robin arbiter.
- Its per-queue buf_empty vector drives the arbiter's buf_empty input.
- The arbiter's selector and out_enb come back as rd_sel and rd_enb; the selected word leaves on data_out with valid_out.

Parameters:
QUEUE_QUANTITY, 4, number of queues (power of two, >= 2)
DATA_BITS, 8, width of each stored word
DEPTH, 8, entries per queue (power of two, >= 2)
ALMOST_FULL_LVL, 6, occupancy at or above which almost_full[q] asserts (1..DEPTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
wr_enb  input  1  write request
wr_sel  input  $clog2(QUEUE_QUANTITY)  destination queue of write
data_in  input  DATA_BITS  write data
rd_enb  input  1  read request (from arbiter out_enb)
rd_sel  input  $clog2(QUEUE_QUANTITY)  source queue of read (from arbiter selector)
data_out  output  DATA_BITS  registered read data
valid_out  output  1  data_out holds a word popped on the previous edge
buf_empty  output  QUEUE_QUANTITY  per-queue empty flag
buf_full  output  QUEUE_QUANTITY  per-queue full flag
almost_full  output  QUEUE_QUANTITY  per-queue occupancy >= ALMOST_FULL_LVL
err_overflow  output  1  one-cycle pulse: write to a full queue dropped
err_underflow  output  1  one-cycle pulse: read from an empty queue ignored

Behaviour:
- Clocking and reset
  - Single clock, synchronous active-high reset.
  - rst has priority over all requests.
  - rst clears, in the same edge: every queue's write pointer, read pointer and count.
  - Reset values after that edge: data_out=0, valid_out=0, err_overflow=0, err_underflow=0, buf_empty all ones, buf_full=0, almost_full=0.
  - Storage array is not reset.
  - Reset mid-operation discards all stored words; no valid_out follows.
- Per-queue state
  - wptr and rptr, each $clog2(DEPTH) bits; both wrap DEPTH-1 -> 0 naturally.
  - count, $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Status outputs
  - Combinational from registered count only, so no input-to-output paths.
  - buf_empty[q] = (count==0).
  - buf_full[q] = (count==DEPTH).
  - almost_full[q] = (count>=ALMOST_FULL_LVL).
- Write
  - Accepted when wr_enb and !buf_full[wr_sel]: mem[wr_sel][wptr] <= data_in, wptr++, count++.
  - Write to a full queue: data dropped, no state change, err_overflow=1 for the following cycle.
- Read
  - Accepted when rd_enb and !buf_empty[rd_sel]: data_out <= mem[rd_sel][rptr], rptr++, count--, valid_out <= 1.
  - Latency is 1 cycle: the word appears on the edge that samples rd_enb.
  - Read from an empty queue: valid_out <= 0, data_out holds its last value, err_underflow=1 for the following cycle.
  - No read request: valid_out <= 0, data_out holds.
- Simultaneous read and write, same queue
  - Empty and flags are evaluated from pre-edge count.
  - Queue empty: write accepted, read rejected as underflow. No write-through bypass, so the word is readable from the next cycle.
  - Queue full: both accepted, count unchanged; the read returns the oldest word.
  - Otherwise: both accepted, count unchanged.
- Simultaneous read and write, different queues: fully independent.
- Ordering: strict FIFO per queue; queues never interact.
- Error pulses: err_overflow and err_underflow are registered and last exactly one cycle per offending request.

Test Plan:
1. Reset, then idle 3 cycles -> buf_empty=4'b1111, buf_full=0, valid_out=0, data_out=0.
2. Write 0x11,0x22,0x33 to queue 2, then read queue 2 on three consecutive cycles -> valid_out high for 3 cycles with data_out 0x11,0x22,0x33, each one cycle after its rd_enb; buf_empty[2] returns to 1.
3. Write 8 words to queue 0 -> almost_full[0] rises after the 6th write and buf_full[0] after the 8th. A 9th write (0xAA) -> err_overflow pulses once. Drain -> 8 original words in order, 0xAA absent.
4. Queue 1 full: same-cycle write 0x5C and read of queue 1 -> count stays 8, buf_full[1] stays 1, oldest word out. 0x5C is the last word returned on drain.
5. Queue 3 empty: same-cycle write 0x77 and read of queue 3 -> err_underflow pulses, valid_out=0. Read next cycle -> 0x77.
6. Fill queue 0 with 5 words, read 2, assert rst for one cycle -> all flags back to reset values, valid_out=0. Subsequent write/read of 0x9E to queue 0 returns 0x9E, confirming pointers restarted at 0.
